rpsc_fault_latch: RTL and testbench



---
 rtl/rpsc_fault_latch.sv | 109 ++++++++++
 tb/tb_rpsc_fault_latch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rpsc_fault_latch.sv
// Six-channel interlock fault front end: 2-flop sync, per-channel debounce, latch until operator clear.
// Raw high sampled at edge n shows on o_ff after edge n+1+DEBOUNCE_CYCLES; no backpressure, outputs are levels.
module rpsc_fault_latch #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         i_fault_raw,
  input  logic               i_clear_req,
  output logic [5:0]         o_ff,
  output logic               o_any_fault,
  output logic [2:0]         o_first_fault,
  output logic [COUNT_W-1:0] o_trip_count
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_QUAL = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TRIP_MAX = '1;

  typedef enum logic {ARMED, TRIPPED} state_t;

  state_t             state_q, state_d;
  logic [6:0]         sync1, sync2;
  logic               clr_d;
  logic [CNT_W-1:0]   cnt [6];
  logic [5:0]         s, qual, ff_next;
  logic               clear_evt;
  logic [2:0]         first_d;
  logic [COUNT_W-1:0] count_d;

  // Clear request rides in bit 6 so all seven async lines share one synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      clr_d <= 1'b0;
    end else begin
      sync1 <= {i_clear_req, i_fault_raw};
      sync2 <= sync1;
      clr_d <= sync2[6];
    end
  end

  assign s         = sync2[5:0];
  assign clear_evt = sync2[6] & ~clr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (!s[k])                cnt[k] <= '0;
        else if (cnt[k] != CNT_MAX) cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

  // Qualify on the single edge the counter reaches the threshold; saturation stops repeats.
  always_comb begin
    qual = '0;
    for (int k = 0; k < 6; k++) qual[k] = s[k] && (cnt[k] == CNT_QUAL);
  end

  // A clear only drops channels whose synchronised line is low; a fresh set always wins.
  assign ff_next = qual | (o_ff & ~({6{clear_evt}} & ~s));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARMED;
      o_ff          <= '0;
      o_first_fault <= '0;
      o_trip_count  <= '0;
    end else begin
      state_q       <= state_d;
      o_ff          <= ff_next;
      o_first_fault <= first_d;
      o_trip_count  <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    first_d = o_first_fault;
    count_d = o_trip_count;
    case (state_q)
      ARMED: begin
        if (ff_next != '0) begin
          state_d = TRIPPED;
          if (o_trip_count != TRIP_MAX) count_d = o_trip_count + COUNT_W'(1);
          for (int k = 5; k >= 0; k--) begin
            if (ff_next[k]) first_d = 3'(k + 1);
          end
        end
      end
      TRIPPED: begin
        if (ff_next == '0) begin
          state_d = ARMED;
          first_d = '0;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  assign o_any_fault = |o_ff;

endmodule

// File: tb/tb_rpsc_fault_latch.sv
// Bench for rpsc_fault_latch: directed vector table, reset/saturation sequences, random stimulus vs history model.
module tb_rpsc_fault_latch;

  localparam int D    = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    i_fault_raw;
  logic          i_clear_req;
  logic [5:0]    o_ff;
  logic          o_any_fault;
  logic [2:0]    o_first_fault;
  logic [CW-1:0] o_trip_count;

  rpsc_fault_latch #(.DEBOUNCE_CYCLES(D), .COUNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_fault_raw   (i_fault_raw),
    .i_clear_req   (i_clear_req),
    .o_ff          (o_ff),
    .o_any_fault   (o_any_fault),
    .o_first_fault (o_first_fault),
    .o_trip_count  (o_trip_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw/clear samples taken at each edge since reset; decisions come from run lengths in that history.
  logic [6:0] hist[$];
  logic [5:0] m_ff;
  int         m_first;
  int         m_count;

  function automatic logic [6:0] samp(input int back);
    if (hist.size() > back) return hist[hist.size() - 1 - back];
    return 7'd0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_ff    = '0;
    m_first = 0;
    m_count = 0;
  endtask

  task automatic model_edge(input logic [5:0] raw, input logic clr);
    logic [6:0] cur, prv, b;
    logic [5:0] nxt;
    int         run;
    hist.push_back({clr, raw});
    if (hist.size() > D + 8) void'(hist.pop_front());
    cur = samp(2);
    prv = samp(3);
    nxt = m_ff;
    for (int k = 0; k < 6; k++) begin
      run = 0;
      for (int j = 2; j <= D + 2; j++) begin
        b = samp(j);
        if (b[k] && run == j - 2) run++;
      end
      if (run == D) nxt[k] = 1'b1;
      else if (cur[6] && !prv[6] && !cur[k]) nxt[k] = 1'b0;
    end
    if (m_ff == 0 && nxt != 0) begin
      m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
      m_first = 0;
      for (int k = 5; k >= 0; k--) if (nxt[k]) m_first = k + 1;
    end
    if (nxt == 0) m_first = 0;
    m_ff = nxt;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ff"},    int'(o_ff),          int'(m_ff));
    chk({tag, ".any"},   int'(o_any_fault),   int'(m_ff != 0));
    chk({tag, ".first"}, int'(o_first_fault), m_first);
    chk({tag, ".count"}, int'(o_trip_count),  m_count);
  endtask

  // Called at a negedge: drive, take one edge, check at the following negedge.
  task automatic step(input logic [5:0] raw, input logic clr, input string tag);
    i_fault_raw = raw;
    i_clear_req = clr;
    @(posedge clk);
    model_edge(raw, clr);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic [5:0] raw;
    logic       clr;
    int         n;
    logic [5:0] ff;
    int         first;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] raw, input logic clr, input int n,
                     input logic [5:0] ff, input int first, input int cnt);
    tbl.push_back('{raw, clr, n, ff, first, cnt});
  endtask

  task automatic clear_seq(input logic [5:0] ff, input int first, input int cnt);
    add(6'b0, 1'b0, 3, ff, first, cnt);
    add(6'b0, 1'b1, 1, ff, first, cnt);
    add(6'b0, 1'b0, 1, ff, first, cnt);
    add(6'b0, 1'b0, 1, 6'b0, 0, cnt);
  endtask

  initial begin
    reset       = 1'b1;
    i_fault_raw = '0;
    i_clear_req = 1'b0;
    model_reset();

    // Single channel trips exactly D+2 edges after first sample
    add(6'b000100, 0, 5, 6'b000000, 0, 0);
    add(6'b000100, 0, 1, 6'b000100, 3, 1);
    clear_seq(6'b000100, 3, 1);
    // Short pulses never latch
    for (int r = 0; r < 5; r++) begin
      add(6'b000001, 0, 3, 6'b0, 0, 1);
      add(6'b000000, 0, 2, 6'b0, 0, 1);
    end
    // Two channels together, then a third while tripped
    add(6'b010010, 0, 6, 6'b010010, 2, 2);
    add(6'b010010, 0, 4, 6'b010010, 2, 2);
    add(6'b110010, 0, 5, 6'b010010, 2, 2);
    add(6'b110010, 0, 1, 6'b110010, 2, 2);
    // Clear with bit 4 still active keeps it latched
    add(6'b010000, 0, 2, 6'b110010, 2, 2);
    add(6'b010000, 1, 1, 6'b110010, 2, 2);
    add(6'b010000, 0, 1, 6'b110010, 2, 2);
    add(6'b010000, 0, 1, 6'b010000, 2, 2);
    clear_seq(6'b010000, 2, 2);
    add(6'b000001, 0, 5, 6'b0, 0, 2);
    add(6'b000001, 0, 1, 6'b000001, 1, 3);
    clear_seq(6'b000001, 1, 3);
    // Clear held high: one event only, latch survives
    add(6'b001000, 1, 6, 6'b001000, 4, 4);
    add(6'b000000, 1, 8, 6'b001000, 4, 4);
    add(6'b000000, 0, 2, 6'b001000, 4, 4);
    add(6'b000000, 1, 1, 6'b001000, 4, 4);
    add(6'b000000, 0, 1, 6'b001000, 4, 4);
    add(6'b000000, 0, 1, 6'b000000, 0, 4);
    // Clear event lands on the qualifying edge
    add(6'b000010, 0, 3, 6'b0, 0, 4);
    add(6'b000010, 1, 1, 6'b0, 0, 4);
    add(6'b000010, 0, 1, 6'b0, 0, 4);
    add(6'b000010, 0, 1, 6'b000010, 2, 5);
    clear_seq(6'b000010, 2, 5);

    #1;
    chk("reset.ff", int'(o_ff), 0);
    chk("reset.any", int'(o_any_fault), 0);
    chk("reset.first", int'(o_first_fault), 0);
    chk("reset.count", int'(o_trip_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < tbl.size(); v++) begin
      for (int c = 0; c < tbl[v].n; c++) step(tbl[v].raw, tbl[v].clr, "vec");
      chk($sformatf("vec%0d.ff", v),    int'(o_ff),          int'(tbl[v].ff));
      chk($sformatf("vec%0d.any", v),   int'(o_any_fault),   int'(tbl[v].ff != 0));
      chk($sformatf("vec%0d.first", v), int'(o_first_fault), tbl[v].first);
      chk($sformatf("vec%0d.count", v), int'(o_trip_count),  tbl[v].cnt);
    end

    // Reset while tripped with the raw line still high
    for (int c = 0; c < D + 2; c++) step(6'b000100, 1'b0, "pre_rst");
    chk("pre_rst.ff", int'(o_ff), 6'b000100);
    reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst.ff", int'(o_ff), 0);
    chk("mid_rst.any", int'(o_any_fault), 0);
    chk("mid_rst.first", int'(o_first_fault), 0);
    chk("mid_rst.count", int'(o_trip_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < D + 1; c++) step(6'b000100, 1'b0, "post_rst");
    chk("post_rst.early", int'(o_ff), 0);
    step(6'b000100, 1'b0, "post_rst");
    chk("post_rst.ff", int'(o_ff), 6'b000100);
    chk("post_rst.count", int'(o_trip_count), 1);

    // Trip counter saturation across many trip/clear cycles
    for (int t = 0; t < CMAX + 2; t++) begin
      for (int c = 0; c < D + 2; c++) step(6'b100000, 1'b0, "sat");
      for (int c = 0; c < 3; c++) step(6'b000000, 1'b0, "sat");
      step(6'b000000, 1'b1, "sat");
      step(6'b000000, 1'b0, "sat");
      step(6'b000000, 1'b0, "sat");
    end
    chk("sat.count", int'(o_trip_count), CMAX);
    chk("sat.ff", int'(o_ff), 0);

    // Random segments: sparse fault patterns, random hold lengths and clear levels
    for (int seg = 0; seg < 400; seg++) begin
      logic [5:0] raw;
      logic       clr;
      int         len;
      raw = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
      clr = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 2 * D + 2);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_model("rand_rst");
        @(negedge clk);
        reset = 1'b0;
      end
      for (int c = 0; c < len; c++) step(raw, clr, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
